data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/sram_array_128x32.sv | 38 +++
 rtl/data_mem_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared sizing defaults, counter width and FSM states.
`default_nettype none

package data_mem_responder_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 128;
  localparam int CNT_W      = 16;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/sram_array_128x32.sv
// sram_array_128x32: word storage with one synchronous write port and a registered read port.
`default_nettype none

module sram_array_128x32 #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself has no reset; it is cleared only by the owner's sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory responder that zero-fills its array after reset, then
// serves active-low CEN/WEN/OEN accesses with saturating access counters.
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              ready,
  output logic              err_busy,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
      err_busy <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_WORD) begin
            state <= IDLE;
          end
          if (!CEN) begin
            err_busy <= 1'b1;
          end
        end
        IDLE: begin
          if (!CEN) begin
            if (!WEN) begin
              if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
            end else begin
              if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = A;
    mem_wdata = D;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_ptr;
      mem_wdata = '0;
    end else if (!CEN) begin
      mem_we = !WEN;
      mem_re = WEN;
    end
  end

  sram_array_128x32 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk   (clk),
    .rst   (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (A),
    .rdata (rd_data)
  );

  assign ready = (state == IDLE);
  assign Q     = OEN ? '0 : rd_data;

endmodule

`default_nettype wire
